// File: rtl/tetris_board_scanner.sv
// tetris_board_scanner
//   Reads the tetris chip's multiplexed output bus by stepping request_location
//   through 0..8, builds a double-buffered snapshot (8 stack heights, 8 drop
//   positions, score) and renders it, plus the live bouncing pixel, onto a
//   row-scanned 8x8 LED matrix.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-low
//   game_running     in   enables the bounce pixel (synchronized)
//   bounce_pos[2:0]  in   column of the bounce pixel on row 7 (synchronized)
//   update_value[7:0] in  {drop_pos,stack_pos} for loc 0-7, score for loc 8
//   request_location[3:0] out  location currently requested from the chip
//   row_sel[7:0]     out  one-hot active-high row enable, bit0 = bottom row
//   col_data[7:0]    out  active-high column data for the selected row
//   score[7:0]       out  score from the last complete scan
//   frame_valid      out  one-cycle pulse when a new snapshot is committed
//
// Scan FSM states
//   state      | meaning
//   ST_SETTLE  | request_location driven, waiting for the chip bus to settle
//   ST_SAMPLE  | capture update_value for the current location into the shadow
//   ST_COMMIT  | copy the complete shadow to the display buffer and score

module tetris_board_scanner #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ROW_HOLD      = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_running,
  input  logic [2:0] bounce_pos,
  input  logic [7:0] update_value,
  output logic [3:0] request_location,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic [7:0] score,
  output logic       frame_valid
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int HW = $clog2(ROW_HOLD);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(ROW_HOLD - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_t;

  scan_state_t   state;
  logic [3:0]    loc;
  logic [SW-1:0] settle_cnt;

  logic [3:0] sh_stk   [8];
  logic [3:0] sh_drp   [8];
  logic [7:0] sh_score;
  logic [3:0] disp_stk [8];
  logic [3:0] disp_drp [8];

  logic       gr_s1, gr_s2;
  logic [2:0] bp_s1, bp_s2;

  logic [HW-1:0] hold_cnt;
  logic [2:0]    row;
  logic [7:0]    row_pixels;

  assign request_location = loc;

  // Settle timer is a down-counter: reloaded on entry to ST_SETTLE, the
  // terminal count of zero moves the FSM to ST_SAMPLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_SETTLE;
      loc         <= 4'd0;
      settle_cnt  <= SETTLE_LOAD;
      frame_valid <= 1'b0;
      score       <= 8'd0;
      sh_score    <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        sh_stk[i]   <= 4'd0;
        sh_drp[i]   <= 4'd0;
        disp_stk[i] <= 4'd0;
        disp_drp[i] <= 4'd0;
      end
    end else begin
      frame_valid <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_SAMPLE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          if (loc == 4'd8) begin
            sh_score    <= update_value;
            frame_valid <= 1'b1;
            state       <= ST_COMMIT;
          end else begin
            sh_stk[loc[2:0]] <= update_value[3:0];
            sh_drp[loc[2:0]] <= update_value[7:4];
            loc              <= loc + 4'd1;
            settle_cnt       <= SETTLE_LOAD;
            state            <= ST_SETTLE;
          end
        end
        ST_COMMIT: begin
          // Whole snapshot moves in one edge so the display never shows a mix
          // of two scans.
          for (int i = 0; i < 8; i++) begin
            disp_stk[i] <= sh_stk[i];
            disp_drp[i] <= sh_drp[i];
          end
          score      <= sh_score;
          loc        <= 4'd0;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
        default: begin
          loc        <= 4'd0;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      gr_s1 <= 1'b0;
      gr_s2 <= 1'b0;
      bp_s1 <= 3'd0;
      bp_s2 <= 3'd0;
    end else begin
      gr_s1 <= game_running;
      gr_s2 <= gr_s1;
      bp_s1 <= bounce_pos;
      bp_s2 <= bp_s1;
    end
  end

  // Pixel row for the current row counter. Comparisons are done at 4 bits so
  // stack heights of 8..15 simply light the whole column.
  always_comb begin
    row_pixels = 8'd0;
    for (int c = 0; c < 8; c++) begin
      if ({1'b0, row} < disp_stk[c])
        row_pixels[c] = 1'b1;
      if ((disp_drp[c] != 4'd0) && (disp_drp[c] <= 4'd8) &&
          ({1'b0, row} == (disp_drp[c] - 4'd1)))
        row_pixels[c] = 1'b1;
      if ((row == 3'd7) && gr_s2 && (bp_s2 == 3'(c)))
        row_pixels[c] = 1'b1;
    end
  end

  // Row scan: the first cycle of every row (hold_cnt == 0) is blanked to
  // avoid ghosting while the row driver switches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_cnt <= '0;
      row      <= 3'd0;
      row_sel  <= 8'd0;
      col_data <= 8'd0;
    end else begin
      if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= '0;
        row      <= row + 3'd1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (hold_cnt == '0) begin
        row_sel  <= 8'd0;
        col_data <= 8'd0;
      end else begin
        row_sel  <= 8'd1 << row;
        col_data <= row_pixels;
      end
    end
  end

endmodule
